// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants, channel-index width helper and channel state record for clk_div_multi
package clk_div_pkg;

  localparam int DEF_CNT_W = 16;
  localparam int DEF_HALF  = 4;

  // Width of a channel index; a single channel still needs one select bit.
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Architectural state of one divider channel at the default counter width.
  typedef struct packed {
    logic [DEF_CNT_W-1:0] cnt;
    logic [DEF_CNT_W-1:0] active;
    logic [DEF_CNT_W-1:0] shadow;
    logic                 pending;
    logic                 out;
  } chan_state_t;

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divider channel: counter, toggle, shadow reload, enable halt, tick (sync with CLK_DIV_SYNC_EN)
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int DEFAULT_HALF = DEF_HALF
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_half,
`ifdef CLK_DIV_SYNC_EN
  input  logic             sync,
`endif
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] active;
  logic [CNT_W-1:0] shadow;
  logic             realign;

`ifdef CLK_DIV_SYNC_EN
  assign realign = sync & enable;
`else
  assign realign = 1'b0;
`endif

  // Counter, toggle and reload: a new half-period only lands when a period ends or the channel is idle.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      active  <= CNT_W'(DEFAULT_HALF);
      shadow  <= CNT_W'(DEFAULT_HALF);
      pending <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      // The host only writes while nothing is pending, so this never races an apply below.
      if (wr) begin
        shadow  <= wr_half;
        pending <= 1'b1;
      end
      if (realign) begin
        cnt     <= '0;
        clk_out <= 1'b0;
        if (pending) begin
          active  <= shadow;
          pending <= 1'b0;
        end
      end else if (enable || clk_out) begin
        // A disabled channel still finishes its high half so the output never glitches.
        if (cnt == active) begin
          cnt     <= '0;
          clk_out <= ~clk_out;
          if (!clk_out) begin
            tick <= 1'b1;
          end else if (pending) begin
            active  <= shadow;
            pending <= 1'b0;
          end
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        // Halted low: hold at the period start and take any waiting reload right away.
        cnt <= '0;
        if (pending) begin
          active  <= shadow;
          pending <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable 50% clock divider top; CLK_DIV_SYNC_EN adds sync_in realign
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter  int CHANNELS     = 4,
  parameter  int CNT_W        = DEF_CNT_W,
  parameter  int DEFAULT_HALF = DEF_HALF,
  localparam int CW           = chan_w(CHANNELS)
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic [CHANNELS-1:0] enable,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CW-1:0]       cfg_chan,
  input  logic [CNT_W-1:0]    cfg_half,
`ifdef CLK_DIV_SYNC_EN
  input  logic                sync_in,
`endif
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick
);

  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] wr;

  // Config decode: a channel accepts only while it has no reload waiting; unknown channels swallow the write.
  always_comb begin
    cfg_ready = 1'b1;
    wr        = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_chan == CW'(i)) cfg_ready = ~pending[i];
    end
    for (int i = 0; i < CHANNELS; i++) begin
      wr[i] = cfg_valid && cfg_ready && (cfg_chan == CW'(i));
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    clk_div_chan #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_chan (
      .clk_in  (clk_in),
      .reset   (reset),
      .enable  (enable[g]),
      .wr      (wr[g]),
      .wr_half (cfg_half),
`ifdef CLK_DIV_SYNC_EN
      .sync    (sync_in),
`endif
      .pending (pending[g]),
      .clk_out (clk_out[g]),
      .tick    (tick[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - self-checking bench for clk_div_multi against a phase-counter reference model
module tb_clk_div_multi;

  localparam int CH    = 5;
  localparam int CW    = 3;
  localparam int CNT_W = 16;

  logic            clk_in = 1'b0;
  logic            reset;
  logic [CH-1:0]   enable;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [CW-1:0]   cfg_chan;
  logic [CNT_W-1:0] cfg_half;
`ifdef CLK_DIV_SYNC_EN
  logic            sync_in;
`endif
  logic [CH-1:0]   clk_out;
  logic [CH-1:0]   tick;

  int checks = 0;
  int errors = 0;
  logic last_ready;

  // Reference: position within the period (edges since the period began), period 2*(H+1), high when past H.
  int m_t[CH];
  int m_h[CH];
  int m_sh[CH];
  bit m_pend[CH];
  bit m_tick[CH];

  clk_div_multi #(
    .CHANNELS     (CH),
    .CNT_W        (CNT_W),
    .DEFAULT_HALF (4)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_half  (cfg_half),
`ifdef CLK_DIV_SYNC_EN
    .sync_in   (sync_in),
`endif
    .clk_out   (clk_out),
    .tick      (tick)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_t[i] = 0; m_h[i] = 4; m_sh[i] = 4; m_pend[i] = 0; m_tick[i] = 0;
    end
  endtask

  function automatic bit model_ready();
    if (int'(cfg_chan) >= CH) return 1'b1;
    return !m_pend[cfg_chan];
  endfunction

  task automatic apply(input int i);
    if (m_pend[i]) begin
      m_h[i] = m_sh[i];
      m_pend[i] = 0;
    end
  endtask

  task automatic model_step();
    bit acc;
    bit sy;
    int wc;
    acc = cfg_valid && model_ready();
    wc  = int'(cfg_chan);
    for (int i = 0; i < CH; i++) begin
      sy = 1'b0;
`ifdef CLK_DIV_SYNC_EN
      sy = sync_in && enable[i];
`endif
      m_tick[i] = 0;
      if (sy) begin
        m_t[i] = 0;
        apply(i);
      end else if (enable[i] || m_t[i] > m_h[i]) begin
        m_t[i]++;
        if (m_t[i] == 2 * (m_h[i] + 1)) begin
          m_t[i] = 0;
          apply(i);
        end else if (m_t[i] == m_h[i] + 1) begin
          m_tick[i] = 1;
        end
      end else begin
        m_t[i] = 0;
        apply(i);
      end
    end
    if (acc && wc < CH) begin
      m_sh[wc]   = int'(cfg_half);
      m_pend[wc] = 1;
    end
  endtask

  // One clock: inputs were set at the preceding falling edge.
  task automatic cycle();
    #1;
    last_ready = cfg_ready;
    chk("cfg_ready", int'(cfg_ready), int'(model_ready()));
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
    for (int i = 0; i < CH; i++) begin
      chk($sformatf("clk_out[%0d]", i), int'(clk_out[i]), (m_t[i] > m_h[i]) ? 1 : 0);
      chk($sformatf("tick[%0d]", i), int'(tick[i]), int'(m_tick[i]));
    end
  endtask

  task automatic wait_high(input int ch);
    int n;
    n = 0;
    while (clk_out[ch] !== 1'b1 && n < 40) begin
      cycle();
      n++;
    end
    chk("wait_high", int'(clk_out[ch]), 1);
  endtask

  initial begin
    int n;
    reset = 1'b1; enable = '0; cfg_valid = 1'b0; cfg_chan = '0; cfg_half = '0;
`ifdef CLK_DIV_SYNC_EN
    sync_in = 1'b0;
`endif
    model_reset();
    repeat (2) @(negedge clk_in);
    #1;
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_ready", int'(cfg_ready), 1);
    @(negedge clk_in);

    // Defaults: first rise on edge 5, period 10.
    reset = 1'b0; enable = '1;
    repeat (4) cycle();
    chk("pre_rise", int'(clk_out), 0);
    cycle();
    chk("first_rise", int'(clk_out), 31);
    chk("first_tick", int'(tick), 31);
    repeat (5) cycle();
    chk("first_fall", int'(clk_out), 0);
    repeat (20) cycle();

    // Reload ch1 to divide-by-2 while it is high.
    wait_high(1);
    cfg_valid = 1'b1; cfg_chan = 3'd1; cfg_half = 16'd0;
    cycle();
    cfg_valid = 1'b0;
    repeat (16) cycle();

    // Back-to-back writes to ch2: second one stalls until the first applies.
    cfg_valid = 1'b1; cfg_chan = 3'd2; cfg_half = 16'd2;
    cycle();
    cfg_half = 16'd6;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_ready && n < 40);
    chk("b2b_accepted", int'(last_ready), 1);
    cfg_valid = 1'b0;
    repeat (30) cycle();

    // Drop enable[0] while high, then re-enable.
    wait_high(0);
    enable[0] = 1'b0;
    repeat (20) cycle();
    chk("halted_low", int'(clk_out[0]), 0);
    enable[0] = 1'b1;
    repeat (20) cycle();

    // Out-of-range channel: accepted and dropped.
    cfg_valid = 1'b1; cfg_chan = 3'd7; cfg_half = 16'd1;
    #1;
    chk("oor_ready", int'(cfg_ready), 1);
    cycle();
    cfg_valid = 1'b0;
    repeat (12) cycle();

`ifdef CLK_DIV_SYNC_EN
    // Realign ch0 (pending reload) and ch3 (H=9) from arbitrary phase.
    cfg_valid = 1'b1; cfg_chan = 3'd3; cfg_half = 16'd9;
    cycle();
    cfg_valid = 1'b0;
    repeat (25) cycle();
    cfg_valid = 1'b1; cfg_chan = 3'd0; cfg_half = 16'd4;
    cycle();
    cfg_valid = 1'b0;
    repeat (3) cycle();
    sync_in = 1'b1;
    cycle();
    sync_in = 1'b0;
    chk("sync_low0", int'(clk_out[0]), 0);
    chk("sync_low3", int'(clk_out[3]), 0);
    repeat (25) cycle();
`endif

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(15) == 0) enable[i] = ~enable[i];
      end
      cfg_valid = $urandom_range(1);
      cfg_chan  = CW'($urandom_range(7));
      cfg_half  = CNT_W'($urandom_range(5));
`ifdef CLK_DIV_SYNC_EN
      sync_in = ($urandom_range(39) == 0);
`endif
      cycle();
    end
    cfg_valid = 1'b0;
`ifdef CLK_DIV_SYNC_EN
    sync_in = 1'b0;
`endif

    // Asynchronous reset mid-operation.
    enable = '1;
    cfg_valid = 1'b1; cfg_chan = 3'd4; cfg_half = 16'd3;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_clk_out", int'(clk_out), 0);
    chk("arst_ready", int'(cfg_ready), 1);
    cfg_valid = 1'b0;
    @(negedge clk_in);
    reset = 1'b0;
    model_reset();
    repeat (25) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
